// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Provides the default request width and the index-width derivation function.
// No logic here; imported by encoder and encoder_prio_comb.
package encoder_pkg;

  localparam int ENC_WIDTH_DEFAULT = 4;

  // Ceiling log2, floored at 1 so a 2-line encoder still gets a 1-bit index.
  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    if (res < 1) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/encoder_prio_comb.sv
// Combinational MSB-priority search with valid and multi-hit detection.
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// Ports: req_i (request vector), idx_o (highest set index), valid_o (any set),
//        multi_o (two or more set).
module encoder_prio_comb
  import encoder_pkg::*;
#(
  parameter  int WIDTH = ENC_WIDTH_DEFAULT,
  localparam int OUT_W = clog2_f(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [OUT_W-1:0] idx_o,
  output logic             valid_o,
  output logic             multi_o
);

  logic seen;

  // Scan low-to-high so the last hit, i.e. the highest set bit, wins.
  // A hit seen while an earlier hit already exists marks a multi-hot input.
  always_comb begin
    idx_o   = '0;
    seen    = 1'b0;
    multi_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i]) begin
        if (seen) begin
          multi_o = 1'b1;
        end
        seen  = 1'b1;
        idx_o = OUT_W'(i);
      end
    end
    valid_o = seen;
  end

endmodule

// File: rtl/encoder.sv
// Registered priority encoder: request vector -> index of highest set bit.
// Latency: 1 cycle, registers update every cycle. Backpressure: none.
// Ports: clk, rst_n (async active-low), encoder_in (requests),
//        encoder_out (index), encoder_valid (any set), encoder_multi (>=2 set).
module encoder
  import encoder_pkg::*;
#(
  parameter  int WIDTH = ENC_WIDTH_DEFAULT,
  localparam int OUT_W = clog2_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] encoder_in,
  output logic [OUT_W-1:0] encoder_out,
  output logic             encoder_valid,
  output logic             encoder_multi
);

  logic [OUT_W-1:0] out_d;
  logic             valid_d;
  logic             multi_d;

  logic [OUT_W-1:0] out_q;
  logic             valid_q;
  logic             multi_q;

  encoder_prio_comb #(
    .WIDTH (WIDTH)
  ) u_prio (
    .req_i   (encoder_in),
    .idx_o   (out_d),
    .valid_o (valid_d),
    .multi_o (multi_d)
  );

  // Outputs come straight from flops, so there is no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign encoder_out   = out_q;
  assign encoder_valid = valid_q;
  assign encoder_multi = multi_q;

endmodule

// File: tb/tb_encoder.sv
// Directed self-checking bench for the registered priority encoder.
// Inputs driven at falling edges, outputs sampled at falling edges or between edges.
// Expected values are hand-computed constants.
module tb_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] encoder_in;
  logic [1:0] encoder_out;
  logic       encoder_valid;
  logic       encoder_multi;

  int errors = 0;
  int checks = 0;

  encoder #(
    .WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .encoder_in    (encoder_in),
    .encoder_out   (encoder_out),
    .encoder_valid (encoder_valid),
    .encoder_multi (encoder_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] e_out,
                      input logic e_valid, input logic e_multi);
    chk({tag, ".out"},   32'(encoder_out),   32'(e_out));
    chk({tag, ".valid"}, 32'(encoder_valid), 32'(e_valid));
    chk({tag, ".multi"}, 32'(encoder_multi), 32'(e_multi));
  endtask

  // Drive at a falling edge; the next rising edge captures; check at the next falling edge.
  task automatic step(input string tag, input logic [3:0] in, input logic [1:0] e_out,
                      input logic e_valid, input logic e_multi);
    encoder_in = in;
    @(negedge clk);
    chk3(tag, e_out, e_valid, e_multi);
  endtask

  logic [3:0] oh_in  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] mh_in  [6] = '{4'b0011, 4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1100};
  logic [1:0] mh_out [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  initial begin
    rst_n      = 1'b1;
    encoder_in = 4'b1000;
    #2 rst_n = 1'b0;
    #1 chk3("rst_async", 2'd0, 1'b0, 1'b0);

    // Clock runs while reset is held: outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk3("rst_hold", 2'd0, 1'b0, 1'b0);
    end

    // Release between edges: nothing changes until the next rising edge.
    rst_n = 1'b1;
    #2 chk3("rst_release_pre_edge", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk3("rst_release_first_edge", 2'd3, 1'b1, 1'b0);

    // One-hot sweep.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("onehot%0d", i), oh_in[i], 2'(i), 1'b1, 1'b0);
    end

    // Multi-hot, MSB priority.
    for (int i = 0; i < 6; i++) begin
      step($sformatf("multihot_%b", mh_in[i]), mh_in[i], mh_out[i], 1'b1, 1'b1);
    end
    step("all_ones", 4'b1111, 2'd3, 1'b1, 1'b1);

    // Zero input, then 0001 which shares index 0 but is valid.
    step("zero", 4'b0000, 2'd0, 1'b0, 1'b0);
    step("after_zero_0001", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Latency: change input just after a rising edge; outputs hold until the next one.
    @(posedge clk);
    #1 encoder_in = 4'b1000;
    @(negedge clk);
    chk3("latency_hold", 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk3("latency_update", 2'd3, 1'b1, 1'b0);

    // Async reset mid-stream.
    @(negedge clk);
    step("pre_reset_1111", 4'b1111, 2'd3, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk3("pre_reset_hold", 2'd3, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk3("midstream_reset", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk3("midstream_reset_hold", 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("post_reset_0100", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
